fp_addsub_pipe: RTL and testbench

//  Pipelined, parametrised IEEE-754-style floating-point add/subtract unit for the ECG filter datapath.

---
 rtl/fp_addsub_pipe.sv | 248 ++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Four-stage floating-point add/subtract with round-to-nearest-even, special-value bypass,
// exception flags and a valid/ready stream interface. All stages advance together.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic [3:0]   flags
);

  localparam int MW   = MAN_W + 4;        // hidden + fraction + guard/round/sticky
  localparam int EW   = EXP_W + 2;        // signed exponent width for range checks
  localparam int LZ_W = $clog2(MW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- Stage 1: unpack, classify, swap, align ----------------
  logic             sa, sb, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, a_ge_b;
  logic [EXP_W-1:0] ea, eb, exp_l, exp_s, diff;
  logic [MAN_W-1:0] fa, fb, frac_l, frac_s;
  logic [MW-1:0]    ms_full, ms_align;
  logic             byp_d;
  logic [W-1:0]     byp_res_d;
  logic [3:0]       byp_flags_d;

  assign sa     = a[W-1];
  assign sb     = b[W-1] ^ sub;
  assign ea     = a[W-2:MAN_W];
  assign eb     = b[W-2:MAN_W];
  assign fa     = a[MAN_W-1:0];
  assign fb     = b[MAN_W-1:0];
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = (ea == EXP_ONES) && (fa == '0);
  assign inf_b  = (eb == EXP_ONES) && (fb == '0);
  assign nan_a  = (ea == EXP_ONES) && (fa != '0);
  assign nan_b  = (eb == EXP_ONES) && (fb != '0);
  assign a_ge_b = a[W-2:0] >= b[W-2:0];
  assign exp_l  = a_ge_b ? ea : eb;
  assign exp_s  = a_ge_b ? eb : ea;
  assign frac_l = a_ge_b ? fa : fb;
  assign frac_s = a_ge_b ? fb : fa;
  assign diff   = exp_l - exp_s;
  assign ms_full = {1'b1, frac_s, 3'b000};

  // Bits shifted past the sticky position collapse into the sticky bit.
  always_comb begin
    ms_align = ms_full >> diff;
    if (32'(diff) >= 32'(MW - 1))
      ms_align = MW'(1);
    else
      ms_align[0] = ms_align[0] | (|(ms_full & ~({MW{1'b1}} << diff)));
  end

  // Zeros (including flushed denormals), infinities and NaNs never enter the datapath.
  always_comb begin
    byp_d       = 1'b1;
    byp_res_d   = '0;
    byp_flags_d = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      byp_res_d   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      byp_flags_d = 4'b1000;
    end else if (inf_a)
      byp_res_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (inf_b)
      byp_res_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
    else if (zero_a && zero_b)
      byp_res_d = {sa & sb, {(W-1){1'b0}}};
    else if (zero_a)
      byp_res_d = {sb, b[W-2:0]};
    else if (zero_b)
      byp_res_d = {sa, a[W-2:0]};
    else
      byp_d = 1'b0;
  end

  logic             s1_valid, s1_byp, s1_sign, s1_eff_sub;
  logic [W-1:0]     s1_byp_res;
  logic [3:0]       s1_byp_flags;
  logic [EXP_W-1:0] s1_exp;
  logic [MW-1:0]    s1_ml, s1_ms;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_byp       <= 1'b0;
      s1_byp_res   <= '0;
      s1_byp_flags <= '0;
      s1_sign      <= 1'b0;
      s1_eff_sub   <= 1'b0;
      s1_exp       <= '0;
      s1_ml        <= '0;
      s1_ms        <= '0;
    end else if (advance) begin
      s1_valid     <= in_valid;
      s1_byp       <= byp_d;
      s1_byp_res   <= byp_res_d;
      s1_byp_flags <= byp_flags_d;
      s1_sign      <= a_ge_b ? sa : sb;
      s1_eff_sub   <= sa ^ sb;
      s1_exp       <= exp_l;
      s1_ml        <= {1'b1, frac_l, 3'b000};
      s1_ms        <= ms_align;
    end
  end

  // ---------------- Stage 2: magnitude add/subtract ----------------
  logic [MW:0] sum_d;
  assign sum_d = s1_eff_sub ? ({1'b0, s1_ml} - {1'b0, s1_ms})
                            : ({1'b0, s1_ml} + {1'b0, s1_ms});

  logic             s2_valid, s2_byp, s2_sign;
  logic [W-1:0]     s2_byp_res;
  logic [3:0]       s2_byp_flags;
  logic [EXP_W-1:0] s2_exp;
  logic [MW:0]      s2_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      s2_byp       <= 1'b0;
      s2_byp_res   <= '0;
      s2_byp_flags <= '0;
      s2_sign      <= 1'b0;
      s2_exp       <= '0;
      s2_sum       <= '0;
    end else if (advance) begin
      s2_valid     <= s1_valid;
      s2_byp       <= s1_byp;
      s2_byp_res   <= s1_byp_res;
      s2_byp_flags <= s1_byp_flags;
      s2_sign      <= s1_sign;
      s2_exp       <= s1_exp;
      s2_sum       <= sum_d;
    end
  end

  // ---------------- Stage 3: leading-zero count and normalise ----------------
  logic [LZ_W-1:0]     lzc;
  logic [MW-1:0]       norm_m;
  logic signed [EW-1:0] exp_ext, norm_e;

  assign exp_ext = $signed({2'b00, s2_exp});

  always_comb begin
    lzc = LZ_W'(MW);
    for (int i = 0; i < MW; i++)
      if (s2_sum[i]) lzc = LZ_W'(MW - 1 - i);
  end

  always_comb begin
    if (s2_sum[MW]) begin
      norm_m = {s2_sum[MW:2], s2_sum[1] | s2_sum[0]};
      norm_e = exp_ext + $signed(EW'(1));
    end else begin
      norm_m = s2_sum[MW-1:0] << lzc;
      norm_e = exp_ext - $signed(EW'(lzc));
    end
  end

  logic                 s3_valid, s3_byp, s3_sign, s3_zero;
  logic [W-1:0]         s3_byp_res;
  logic [3:0]           s3_byp_flags;
  logic signed [EW-1:0] s3_exp;
  logic [MW-1:0]        s3_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid     <= 1'b0;
      s3_byp       <= 1'b0;
      s3_byp_res   <= '0;
      s3_byp_flags <= '0;
      s3_sign      <= 1'b0;
      s3_zero      <= 1'b0;
      s3_exp       <= '0;
      s3_m         <= '0;
    end else if (advance) begin
      s3_valid     <= s2_valid;
      s3_byp       <= s2_byp;
      s3_byp_res   <= s2_byp_res;
      s3_byp_flags <= s2_byp_flags;
      s3_sign      <= s2_sign;
      s3_zero      <= (s2_sum == '0);
      s3_exp       <= norm_e;
      s3_m         <= norm_m;
    end
  end

  // ---------------- Stage 4: round, pack, flag ----------------
  logic                 round_up, inexact_d;
  logic [MAN_W+1:0]     rnd_m;
  logic signed [EW-1:0] rnd_e;
  logic [MAN_W-1:0]     rnd_frac;
  logic [W-1:0]         res_d;
  logic [3:0]           flags_d;

  assign round_up  = s3_m[2] & (s3_m[3] | s3_m[1] | s3_m[0]);
  assign rnd_m     = {1'b0, s3_m[MW-1:3]} + (MAN_W+2)'(round_up);
  assign rnd_e     = s3_exp + $signed(EW'(rnd_m[MAN_W+1]));
  assign rnd_frac  = rnd_m[MAN_W+1] ? rnd_m[MAN_W:1] : rnd_m[MAN_W-1:0];
  assign inexact_d = |s3_m[2:0];

  always_comb begin
    res_d   = '0;
    flags_d = '0;
    if (s3_byp) begin
      res_d   = s3_byp_res;
      flags_d = s3_byp_flags;
    end else if (s3_zero) begin
      res_d = '0;
    end else if (s3_exp[EW-1] || (s3_exp == '0)) begin
      res_d   = {s3_sign, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else if (rnd_e >= $signed({2'b00, EXP_ONES})) begin
      res_d   = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else begin
      res_d   = {s3_sign, rnd_e[EXP_W-1:0], rnd_frac};
      flags_d = {3'b000, inexact_d};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= s3_valid;
      res       <= res_d;
      flags     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed spec cases plus randomized stream with backpressure,
// checked against an exact-arithmetic reference model through an in-order scoreboard.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, res;
  logic [3:0]  flags;

  fp_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [3:0]  prev_flags;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Exact reference: operands become integers in units of 2^-149, summed, then rounded RNE.
  function automatic logic [35:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic sx, sy, sign, up, inx;
    logic [7:0] ex, ey;
    logic [22:0] fx, fy;
    logic signed [299:0] vx, vy, sm;
    logic [299:0] mag, rem, half;
    logic [24:0] m;
    int p, e;
    sx = x[31]; sy = y[31] ^ s;
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0]; fy = y[22:0];
    if ((ex == 8'hFF && fx != 0) || (ey == 8'hFF && fy != 0) ||
        (ex == 8'hFF && ey == 8'hFF && sx != sy))
      return {4'b1000, 32'h7FC00000};
    if (ex == 8'hFF) return {4'b0000, sx, 8'hFF, 23'h0};
    if (ey == 8'hFF) return {4'b0000, sy, 8'hFF, 23'h0};
    if (ex == 0 && ey == 0) return {4'b0000, sx & sy, 31'h0};
    vx = 0; vy = 0;
    if (ex != 0) begin vx = 300'({1'b1, fx}); vx = vx << (int'(ex) - 1); end
    if (ey != 0) begin vy = 300'({1'b1, fy}); vy = vy << (int'(ey) - 1); end
    if (sx) vx = -vx;
    if (sy) vy = -vy;
    sm = vx + vy;
    if (sm == 0) return 36'h0;
    sign = (sm < 0);
    mag = sign ? -sm : sm;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) return {4'b0011, sign, 31'h0};
    m = 25'(mag >> (p - 23));
    rem = mag & ((300'b1 << (p - 23)) - 1);
    half = (p > 23) ? (300'b1 << (p - 24)) : 300'b0;
    inx = (rem != 0);
    up = (p > 23) && ((rem > half) || (rem == half && m[0]));
    m = m + 25'(up);
    if (m[24]) begin m = m >> 1; e++; end
    if (e >= 255) return {4'b0101, sign, 8'hFF, 23'h0};
    return {3'b000, inx, sign, 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op(input logic [31:0] other);
    int k, e;
    logic [31:0] v;
    k = int'($urandom_range(0, 19));
    v = $urandom;
    case (k)
      0: v[30:23] = 8'h00;
      1: v[30:0]  = {8'hFF, 23'h0};
      2: begin v[30:23] = 8'hFF; if (v[22:0] == 0) v[0] = 1'b1; end
      3: v[30:23] = 8'(253 + $urandom_range(0, 1));
      4: v[30:23] = 8'($urandom_range(1, 3));
      5, 6, 7: v = other ^ 32'($urandom_range(0, 7));
      8, 9, 10: begin
        e = int'(other[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        v[30:23] = 8'(e);
      end
      default: v[30:23] = 8'($urandom_range(100, 160));
    endcase
    return v;
  endfunction

  // One clock cycle: drive at the falling edge, then check outputs and score handshakes.
  task automatic cycle(input bit v, input logic [31:0] ta, input logic [31:0] tbv, input bit ts,
                       input bit ordy, input bit use_exp, input logic [35:0] xexp);
    exp_t e;
    logic [35:0] r;
    @(negedge clk);
    cyc++;
    in_valid = v; a = ta; b = tbv; sub = ts; out_ready = ordy;
    #1;
    chk("in_ready", 40'(in_ready), 40'(!out_valid || ordy));
    if (prev_stall) begin
      chk("hold_valid", 40'(out_valid), 40'd1);
      chk("hold_res", 40'({flags, res}), 40'({prev_flags, prev_res}));
    end
    prev_stall = out_valid && !ordy;
    prev_res   = res;
    prev_flags = flags;
    if (out_valid && ordy) begin
      if (q.size() == 0) chk("spurious", 40'(out_valid), 40'd0);
      else begin
        e = q.pop_front();
        chk("result", 40'({flags, res}), 40'({e.flags, e.res}));
        if (chk_lat) chk("latency", 40'(cyc - e.cyc), 40'd4);
      end
    end
    if (v && in_ready) begin
      r = use_exp ? xexp : ref_add(ta, tbv, ts);
      e.res = r[31:0]; e.flags = r[35:32]; e.cyc = cyc;
      q.push_back(e);
      $display("op a=%h b=%h sub=%0d -> expect res=%h flags=%b", ta, tbv, ts, e.res, e.flags);
    end
  endtask

  task automatic op(input logic [31:0] ta, input logic [31:0] tbv, input bit ts, input logic [35:0] want);
    cycle(1'b1, ta, tbv, ts, 1'b1, 1'b1, want);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 36'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 40'({out_valid, flags, res}), 40'h0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 40'(in_ready), 40'd1);

    // Directed cases with exact expected values, output never stalled.
    chk_lat = 1'b1;
    op(32'h3F800000, 32'h3F800000, 1'b0, {4'b0000, 32'h40000000});
    op(32'h40400000, 32'h40400000, 1'b1, {4'b0000, 32'h00000000});
    op(32'h80000000, 32'h80000000, 1'b0, {4'b0000, 32'h80000000});
    op(32'h80000000, 32'h00000000, 1'b1, {4'b0000, 32'h80000000});
    op(32'h3F800000, 32'h33800000, 1'b0, {4'b0001, 32'h3F800000});
    op(32'h3F800000, 32'h33800001, 1'b0, {4'b0001, 32'h3F800001});
    op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {4'b0101, 32'h7F800000});
    op(32'h7F800000, 32'hFF800000, 1'b0, {4'b1000, 32'h7FC00000});
    op(32'h7FC00001, 32'h3F800000, 1'b0, {4'b1000, 32'h7FC00000});
    op(32'hFF800000, 32'h3F800000, 1'b0, {4'b0000, 32'hFF800000});
    op(32'h00000001, 32'h3F800000, 1'b1, {4'b0000, 32'hBF800000});
    op(32'h00800001, 32'h00800000, 1'b1, {4'b0011, 32'h00000000});
    op(32'h3F800000, 32'h3F7FFFFF, 1'b1, {4'b0000, 32'h33800000});
    idle(6);

    // Back-to-back stream with a stall window on the output.
    chk_lat = 1'b0;
    for (int i = 0; i < 14; i++) begin
      ra = 32'h3F800000 + 32'(i << 20);
      rb = 32'h40000000 + 32'(i * 3);
      cycle(i < 8, ra, rb, i[0], !(i >= 3 && i <= 6), 1'b0, 36'h0);
    end
    idle(8);
    chk("stream_drained", 40'(q.size()), 40'd0);

    // Reset with three operations in flight: they must vanish.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h40A00000, 32'h3F800000, 1'b0, 1'b1, 1'b0, 36'h0);
    @(negedge clk);
    #2 rst = 1'b1; in_valid = 1'b0;
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 36'h0);
      chk("rst_quiet", 40'(out_valid), 40'd0);
    end
    chk_lat = 1'b1;
    op(32'h3F800000, 32'h3F800000, 1'b0, {4'b0000, 32'h40000000});
    idle(6);
    chk("post_rst_drained", 40'(q.size()), 40'd0);

    // Randomized traffic with random bubbles and backpressure.
    chk_lat = 1'b0;
    for (int n = 0; n < 600; n++) begin
      ra = rnd_op($urandom);
      rb = rnd_op(ra);
      cycle($urandom_range(0, 4) != 0, ra, rb, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, 1'b0, 36'h0);
    end
    idle(20);
    chk("final_drained", 40'(q.size()), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
